// File: rtl/riscv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscv_ctrl_pkg
//   Shared constants and types for the multi-cycle RISC-V control sequencer:
//   opcode / funct3 / funct7 encodings, ALUControl codes, the sequencer state
//   enum and the decoded operation-class enum.
// -----------------------------------------------------------------------------
package riscv_ctrl_pkg;

  // Opcodes of the supported instruction subset
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ADDI   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 encodings
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_LD      = 3'b011;
  localparam logic [2:0] F3_SD      = 3'b011;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  // funct7 encodings (bit 5 distinguishes SUB from ADD)
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALUControl codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_R    = 3'd0,
    OP_ADDI = 3'd1,
    OP_LD   = 3'd2,
    OP_SD   = 3'd3,
    OP_BEQ  = 3'd4,
    OP_ILL  = 3'd5
  } op_class_t;

  // True for the classes that pass through the MEM state
  function automatic logic is_mem_op(input op_class_t op);
    return (op == OP_LD) || (op == OP_SD);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
//   Purely combinational instruction classifier.
//   Ports:
//     i_instr     in  32  instruction word from the IR
//     o_op_class  out  3  operation class (OP_ILL for anything unsupported)
//     o_alu_ctrl  out  4  ALU operation for the EXEC/MEM/WB states
//     o_alu_src   out  1  0 = rs2 operand, 1 = immediate operand
// -----------------------------------------------------------------------------
module ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  output op_class_t   o_op_class,
  output logic [3:0]  o_alu_ctrl,
  output logic        o_alu_src
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_unused_bits;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];

  // Register/immediate fields are the datapath's business, not the sequencer's
  assign w_unused_bits = ^{i_instr[24:15], i_instr[11:7]};

  always_comb begin
    o_op_class = OP_ILL;
    o_alu_ctrl = ALU_ADD;
    o_alu_src  = 1'b0;
    case (w_opcode)
      OPC_RTYPE: begin
        if (w_funct7 == F7_BASE) begin
          case (w_funct3)
            F3_ADD_SUB: begin o_op_class = OP_R; o_alu_ctrl = ALU_ADD; end
            F3_AND:     begin o_op_class = OP_R; o_alu_ctrl = ALU_AND; end
            F3_OR:      begin o_op_class = OP_R; o_alu_ctrl = ALU_OR;  end
            default:    o_op_class = OP_ILL;
          endcase
        end else if (w_funct7 == F7_ALT && w_funct3 == F3_ADD_SUB) begin
          o_op_class = OP_R;
          o_alu_ctrl = ALU_SUB;
        end
      end
      OPC_ADDI: begin
        if (w_funct3 == F3_ADDI) begin
          o_op_class = OP_ADDI;
          o_alu_src  = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (w_funct3 == F3_LD) begin
          o_op_class = OP_LD;
          o_alu_src  = 1'b1;
        end
      end
      OPC_STORE: begin
        if (w_funct3 == F3_SD) begin
          o_op_class = OP_SD;
          o_alu_src  = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (w_funct3 == F3_BEQ) begin
          o_op_class = OP_BEQ;
          o_alu_ctrl = ALU_SUB;
        end
      end
      default: o_op_class = OP_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle sequencer for a 64-bit RISC-V datapath. Steps each instruction
//   through FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes.
//   Parameters:
//     MEM_TIMEOUT  max non-ready MEM cycles before abort (0 = wait forever)
//     CNT_W        performance counter width
//   Ports:
//     clk, reset (sync, active high), run (level, gates FETCH)
//     instr[31:0], zero_flag, mem_ready                  -- inputs
//     pc_write, ir_write, pc_src, ALUSrc, ALUControl[3:0],
//     MemRead, MemWrite, MemtoReg, RegWrite              -- datapath strobes
//     illegal_instr, mem_err                             -- one-cycle pulses
//     cycle_cnt, retired_cnt [CNT_W-1:0]                 -- perf counters
//   Build option: define PERF_CNT_EN to build the performance counters;
//   otherwise cycle_cnt and retired_cnt are tied to zero.
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             pc_src,
  output logic             ALUSrc,
  output logic [3:0]       ALUControl,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             illegal_instr,
  output logic             mem_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam int WAIT_W     = TIMEOUT_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  state_t           r_state;
  state_t           w_state_next;
  op_class_t        r_op;
  logic [3:0]       r_alu_ctrl;
  logic             r_alu_src;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_next;

  op_class_t        w_dec_op;
  logic [3:0]       w_dec_alu_ctrl;
  logic             w_dec_alu_src;
  logic             w_timeout;

  ctrl_decode u_decode (
    .i_instr    (instr),
    .o_op_class (w_dec_op),
    .o_alu_ctrl (w_dec_alu_ctrl),
    .o_alu_src  (w_dec_alu_src)
  );

  assign w_timeout = TIMEOUT_EN && (r_wait == WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FETCH;
      r_op       <= OP_ILL;
      r_alu_ctrl <= '0;
      r_alu_src  <= 1'b0;
      r_wait     <= '0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
      if (r_state == DECODE) begin
        r_op       <= w_dec_op;
        r_alu_ctrl <= w_dec_alu_ctrl;
        r_alu_src  <= w_dec_alu_src;
      end
    end
  end

  // Next state and strobes. Everything is forced low while reset is high so an
  // interrupted instruction cannot emit a strobe in the reset cycle.
  always_comb begin
    w_state_next  = r_state;
    w_wait_next   = '0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    pc_src        = 1'b0;
    ALUSrc        = 1'b0;
    ALUControl    = '0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    illegal_instr = 1'b0;
    mem_err       = 1'b0;
    if (!reset) begin
      case (r_state)
        FETCH: begin
          if (run) begin
            ir_write     = 1'b1;
            w_state_next = DECODE;
          end
        end
        DECODE: begin
          if (w_dec_op == OP_ILL) begin
            // Skip the instruction: advance PC to PC+4 without retiring it
            illegal_instr = 1'b1;
            pc_write      = 1'b1;
            w_state_next  = FETCH;
          end else begin
            w_state_next = EXEC;
          end
        end
        EXEC: begin
          ALUSrc     = r_alu_src;
          ALUControl = r_alu_ctrl;
          if (r_op == OP_BEQ) begin
            pc_write     = 1'b1;
            pc_src       = zero_flag;
            w_state_next = FETCH;
          end else if (is_mem_op(r_op)) begin
            w_state_next = MEM;
          end else begin
            w_state_next = WB;
          end
        end
        MEM: begin
          // ALU keeps computing the address so it stays stable for the memory
          ALUSrc     = r_alu_src;
          ALUControl = r_alu_ctrl;
          if (w_timeout) begin
            // Abort cycle: access strobes drop, instruction is dropped
            mem_err      = 1'b1;
            pc_write     = 1'b1;
            w_state_next = FETCH;
          end else begin
            MemRead  = (r_op == OP_LD);
            MemWrite = (r_op == OP_SD);
            if (mem_ready) begin
              if (r_op == OP_SD) begin
                pc_write     = 1'b1;
                w_state_next = FETCH;
              end else begin
                w_state_next = WB;
              end
            end else begin
              w_wait_next = TIMEOUT_EN ? r_wait + 1'b1 : '0;
            end
          end
        end
        WB: begin
          ALUSrc       = r_alu_src;
          ALUControl   = r_alu_ctrl;
          RegWrite     = 1'b1;
          MemtoReg     = (r_op == OP_LD);
          pc_write     = 1'b1;
          w_state_next = FETCH;
        end
        default: w_state_next = FETCH;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_retired_cnt;
  logic             w_retire;

  // A PC update retires the instruction unless it skips or aborts it
  assign w_retire = pc_write & ~illegal_instr & ~mem_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
    end else begin
      if (run) begin
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
      end
      if (w_retire) begin
        r_retired_cnt <= r_retired_cnt + 1'b1;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign retired_cnt = r_retired_cnt;
`else
  assign cycle_cnt   = '0;
  assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl. Each instruction pushes its expected
//   per-cycle strobe trace onto a scoreboard queue; the trace is popped and
//   compared cycle by cycle as the DUT steps through the instruction.
//   Strobe vector order:
//   {pc_write, ir_write, pc_src, ALUSrc, ALUControl[3:0],
//    MemRead, MemWrite, MemtoReg, RegWrite, illegal_instr, mem_err}
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [31:0] instr;
  logic        zero_flag;
  logic        mem_ready;
  logic        pc_write, ir_write, pc_src, ALUSrc;
  logic [3:0]  ALUControl;
  logic        MemRead, MemWrite, MemtoReg, RegWrite, illegal_instr, mem_err;
  logic [31:0] cycle_cnt, retired_cnt;
  logic [13:0] obs;

  multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .instr         (instr),
    .zero_flag     (zero_flag),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .pc_src        (pc_src),
    .ALUSrc        (ALUSrc),
    .ALUControl    (ALUControl),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .MemtoReg      (MemtoReg),
    .RegWrite      (RegWrite),
    .illegal_instr (illegal_instr),
    .mem_err       (mem_err),
    .cycle_cnt     (cycle_cnt),
    .retired_cnt   (retired_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, ir_write, pc_src, ALUSrc, ALUControl,
                MemRead, MemWrite, MemtoReg, RegWrite, illegal_instr, mem_err};

  typedef enum {C_R, C_ADDI, C_LD, C_SD, C_BEQ, C_ILL} cls_e;
  typedef struct {
    logic [13:0] vec;
    bit          rdy;
    string       ph;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_cyc = '0;
  logic [31:0] exp_ret = '0;

  function automatic logic [13:0] mk(input bit pcw, input bit irw, input bit pcs,
                                     input bit asrc, input logic [3:0] actl,
                                     input bit mr, input bit mw, input bit m2r,
                                     input bit rw, input bit ill, input bit merr);
    return {pcw, irw, pcs, asrc, actl, mr, mw, m2r, rw, ill, merr};
  endfunction

  task automatic push(input logic [13:0] v, input bit rdy, input string ph);
    exp_t e;
    e.vec = v;
    e.rdy = rdy;
    e.ph  = ph;
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  // One clock: compare strobes (and optionally counters) mid-cycle, then
  // advance the reference counters on the active edge.
  task automatic step_check(input string tag, input logic [13:0] e, input bit do_cnt);
    @(negedge clk);
    check(tag, obs, e);
    if (do_cnt) begin
`ifdef PERF_CNT_EN
      check({tag, ".cycle_cnt"}, cycle_cnt, exp_cyc);
      check({tag, ".retired_cnt"}, retired_cnt, exp_ret);
`else
      check({tag, ".cycle_cnt"}, cycle_cnt, 0);
      check({tag, ".retired_cnt"}, retired_cnt, 0);
`endif
    end
    @(posedge clk);
    if (reset) begin
      exp_cyc = '0;
      exp_ret = '0;
    end else begin
      if (run) exp_cyc++;
      if (e[13] && !e[1] && !e[0]) exp_ret++;
    end
    #1;
  endtask

  // Build the expected trace for one instruction, then drive and check it.
  // stall: non-ready MEM cycles (>= TMO means timeout); consume < 0 runs the
  // whole trace, otherwise stops after that many cycles.
  task automatic exec_instr(input string name, input logic [31:0] ins, input cls_e c,
                            input logic [3:0] actl, input bit asrc, input bit zf,
                            input int stall, input int consume, input bit drop_run);
    exp_t e;
    int   n;
    bit   ld, sdx;
    ld  = (c == C_LD);
    sdx = (c == C_SD);
    instr     = ins;
    zero_flag = zf;
    mem_ready = 1'b0;
    run       = 1'b1;
    push(mk(0,1,0,0,4'h0,0,0,0,0,0,0), 1'b0, "F");
    if (c == C_ILL) begin
      push(mk(1,0,0,0,4'h0,0,0,0,0,1,0), 1'b0, "D");
    end else begin
      push(mk(0,0,0,0,4'h0,0,0,0,0,0,0), 1'b0, "D");
      if (c == C_BEQ) begin
        push(mk(1,0,zf,asrc,actl,0,0,0,0,0,0), 1'b0, "E");
      end else begin
        push(mk(0,0,0,asrc,actl,0,0,0,0,0,0), 1'b0, "E");
        if (ld || sdx) begin
          for (int k = 0; k <= TMO; k++) begin
            if (k == TMO) begin
              push(mk(1,0,0,asrc,actl,0,0,0,0,0,1), 1'b0, "M");
              break;
            end
            if (k >= stall) begin
              push(mk(sdx,0,0,asrc,actl,ld,sdx,0,0,0,0), 1'b1, "M");
              break;
            end
            push(mk(0,0,0,asrc,actl,ld,sdx,0,0,0,0), 1'b0, "M");
          end
        end
        if (!sdx && !(ld && stall >= TMO)) begin
          push(mk(1,0,0,asrc,actl,0,0,ld,1,0,0), 1'b0, "W");
        end
      end
    end
    n = 0;
    while (sb.size() > 0 && (consume < 0 || n < consume)) begin
      e = sb.pop_front();
      mem_ready = e.rdy;
      step_check($sformatf("%s.%s%0d", name, e.ph, n), e.vec, 1'b0);
      if (drop_run && n == 0) run = 1'b0;
      n++;
    end
    sb.delete();
    run       = 1'b0;
    mem_ready = 1'b0;
    $display("instr %-8s %08h cycles=%0d", name, ins, n);
  endtask

  task automatic idle_check(input string name);
    step_check({name, ".idle"}, 14'h0, 1'b1);
  endtask

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    run       = 1'b0;
    instr     = '0;
    zero_flag = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step_check("reset", 14'h0, 1'b1);
    reset = 1'b0;
    idle_check("after_reset");

    // ALU register/immediate ops
    exec_instr("add",  32'h002081B3, C_R,    4'b0010, 1'b0, 1'b0, 0, -1, 1'b0);
    idle_check("add");
    exec_instr("sub",  32'h402081B3, C_R,    4'b0110, 1'b0, 1'b0, 0, -1, 1'b0);
    idle_check("sub");
    exec_instr("and",  32'h0020F1B3, C_R,    4'b0000, 1'b0, 1'b0, 0, -1, 1'b0);
    idle_check("and");
    exec_instr("or",   32'h0020E1B3, C_R,    4'b0001, 1'b0, 1'b0, 0, -1, 1'b0);
    idle_check("or");
    exec_instr("addi", 32'h00500093, C_ADDI, 4'b0010, 1'b1, 1'b0, 0, -1, 1'b0);
    idle_check("addi");

    // Loads and stores, with and without memory stalls
    exec_instr("ld_w2", 32'h0080B283, C_LD, 4'b0010, 1'b1, 1'b0, 2, -1, 1'b0);
    idle_check("ld_w2");
    exec_instr("ld_w0", 32'h0080B283, C_LD, 4'b0010, 1'b1, 1'b0, 0, -1, 1'b0);
    idle_check("ld_w0");
    exec_instr("sd_w1", 32'h0020B423, C_SD, 4'b0010, 1'b1, 1'b0, 1, -1, 1'b0);
    idle_check("sd_w1");

    // Branches, taken and not taken
    exec_instr("beq_t", 32'h00208463, C_BEQ, 4'b0110, 1'b0, 1'b1, 0, -1, 1'b0);
    idle_check("beq_t");
    exec_instr("beq_n", 32'h00208463, C_BEQ, 4'b0110, 1'b0, 1'b0, 0, -1, 1'b0);
    idle_check("beq_n");

    // Store that never completes: times out, not retired
    exec_instr("sd_tmo", 32'h0020B423, C_SD, 4'b0010, 1'b1, 1'b0, 1000, -1, 1'b0);
    idle_check("sd_tmo");
    // Load completing on the last allowed wait cycle
    exec_instr("ld_w15", 32'h0080B283, C_LD, 4'b0010, 1'b1, 1'b0, TMO - 1, -1, 1'b0);
    idle_check("ld_w15");

    // Unsupported encodings
    exec_instr("ill_ff",   32'hFFFFFFFF, C_ILL, 4'b0000, 1'b0, 1'b0, 0, -1, 1'b0);
    idle_check("ill_ff");
    exec_instr("ill_slli", 32'h00109093, C_ILL, 4'b0000, 1'b0, 1'b0, 0, -1, 1'b0);
    idle_check("ill_slli");
    exec_instr("ill_mul",  32'h022081B3, C_ILL, 4'b0000, 1'b0, 1'b0, 0, -1, 1'b0);
    idle_check("ill_mul");

    // run dropping after FETCH must not stall the instruction
    exec_instr("add_drop", 32'h002081B3, C_R, 4'b0010, 1'b1 & 1'b0, 1'b0, 0, -1, 1'b1);
    idle_check("add_drop");

    // Reset in the second MEM cycle of a stalled ld
    exec_instr("ld_rst", 32'h0080B283, C_LD, 4'b0010, 1'b1, 1'b0, 1000, 4, 1'b0);
    reset = 1'b1;
    run   = 1'b1;
    step_check("rst_in_mem", 14'h0, 1'b0);
    reset = 1'b0;
    run   = 1'b0;
    idle_check("post_rst0");
    idle_check("post_rst1");
    idle_check("post_rst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
